dram_load_seq: RTL and testbench

- Diagnostic sequencer that loads the instruction dispatch RAM (DRAM: A, B, J fields plus odd parity, indexed by 9-bit opcode address).
- Accepts a block request (start address, word count) and a stream of 16-bit DRAM words over a valid/ready handshake.
- Generates parity and drives address, data and a timed write strobe; optionally reads each entry back and compares it.
- Holds off CON dispatch reads while busy; sits between the diagnostic/EBUS load path and the IR/DRAM board.

---
 rtl/dram_load_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_dram_load_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_load_seq.sv
// -----------------------------------------------------------------------------
// dram_load_seq
//
// Diagnostic sequencer that loads the instruction dispatch RAM (DRAM). A block
// request (start address + word count) is followed by a stream of 16-bit words
// {A[2:0], B[2:0], J[9:0]}. Each word gets an odd-parity bit and is written with
// a timed active-low strobe. Optionally each entry is read back and compared.
// While a block is in progress busy_h holds off CON dispatch reads.
//
// Parameters
//   ADDR_W      DRAM address width (512 entries by default)
//   STROBE_CYC  cycles dram_we_l is held low per write (1..7)
//   HOLD_CYC    cycles address/data are held after strobe release (0..7)
//
// Ports
//   clk_h            system clock, all state changes on the rising edge
//   reset_l          synchronous active-low reset
//   start_h          block request pulse, sampled only when idle
//   start_addr       first DRAM address of the block
//   count            number of words to load (0..512)
//   verify_h         read-back compare enable, latched at start
//   abort_h          finish the block after the current word
//   wd_valid_h       write-data valid
//   wd_ready_h       sequencer can accept a word
//   wd_data          16-bit DRAM word
//   con_load_dram_l  CON dispatch read in progress (active low)
//   dram_addr        DRAM address
//   dram_wdata       {odd_parity, wd_data}
//   dram_we_l        DRAM write strobe, active low
//   dram_rdata       DRAM read data, valid one cycle after dram_addr
//   busy_h           block in progress
//   done_h           one-cycle pulse at block end
//   err_h            sticky error flag (cleared at the next start)
//   err_addr         first failing address
// -----------------------------------------------------------------------------
module dram_load_seq #(
    parameter int ADDR_W     = 9,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk_h,
    input  logic              reset_l,
    input  logic              start_h,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [9:0]        count,
    input  logic              verify_h,
    input  logic              abort_h,
    input  logic              wd_valid_h,
    output logic              wd_ready_h,
    input  logic [15:0]       wd_data,
    input  logic              con_load_dram_l,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [16:0]       dram_wdata,
    output logic              dram_we_l,
    input  logic [16:0]       dram_rdata,
    output logic              busy_h,
    output logic              done_h,
    output logic              err_h,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PEND,       // start accepted, waiting for CON dispatch read to finish
        S_ARM,
        S_WAIT_DATA,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_VRD,
        S_VCMP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] base_addr_reg;
    logic [9:0]        remaining_reg;
    logic              verify_reg;
    logic              abort_seen_reg;
    logic [2:0]        tmr_reg;

    // Abort is remembered for the whole block but only honoured between words,
    // so a strobe already under way always completes at full length.
    wire abort_any = abort_seen_reg | abort_h;

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            state_reg      <= S_IDLE;
            base_addr_reg  <= '0;
            remaining_reg  <= '0;
            verify_reg     <= 1'b0;
            abort_seen_reg <= 1'b0;
            tmr_reg        <= '0;
            wd_ready_h     <= 1'b0;
            dram_addr      <= '0;
            dram_wdata     <= '0;
            dram_we_l      <= 1'b1;
            busy_h         <= 1'b0;
            done_h         <= 1'b0;
            err_h          <= 1'b0;
            err_addr       <= '0;
        end else begin
            done_h <= 1'b0;

            if (state_reg != S_IDLE) begin
                abort_seen_reg <= abort_any;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start_h) begin
                        base_addr_reg  <= start_addr;
                        remaining_reg  <= count;
                        verify_reg     <= verify_h;
                        abort_seen_reg <= 1'b0;
                        err_h          <= 1'b0;
                        err_addr       <= '0;
                        if (int'(count) > DEPTH) begin
                            // Oversized request: flag it and finish without
                            // ever claiming the DRAM.
                            err_h    <= 1'b1;
                            err_addr <= start_addr;
                            done_h   <= 1'b1;
                        end else if (count == 10'd0) begin
                            done_h <= 1'b1;
                        end else if (!con_load_dram_l) begin
                            state_reg <= S_PEND;
                        end else begin
                            state_reg <= S_ARM;
                            busy_h    <= 1'b1;
                            dram_addr <= start_addr;
                        end
                    end
                end

                S_PEND: begin
                    if (con_load_dram_l) begin
                        state_reg <= S_ARM;
                        busy_h    <= 1'b1;
                        dram_addr <= base_addr_reg;
                    end
                end

                S_ARM: begin
                    state_reg  <= S_WAIT_DATA;
                    wd_ready_h <= 1'b1;
                end

                S_WAIT_DATA: begin
                    if (wd_valid_h && wd_ready_h) begin
                        wd_ready_h <= 1'b0;
                        dram_wdata <= {~^wd_data, wd_data};
                        state_reg  <= S_SETUP;
                    end else if (abort_any) begin
                        // No word pending: nothing left to finish.
                        wd_ready_h <= 1'b0;
                        done_h     <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                end

                S_SETUP: begin
                    dram_we_l <= 1'b0;
                    tmr_reg   <= 3'(STROBE_CYC - 1);
                    state_reg <= S_STROBE;
                end

                S_STROBE: begin
                    if (tmr_reg == 3'd0) begin
                        dram_we_l <= 1'b1;
                        if (HOLD_CYC > 0) begin
                            tmr_reg   <= 3'(HOLD_CYC - 1);
                            state_reg <= S_HOLD;
                        end else if (verify_reg) begin
                            state_reg <= S_VRD;
                        end else begin
                            state_reg <= S_NEXT;
                        end
                    end else begin
                        tmr_reg <= tmr_reg - 3'd1;
                    end
                end

                S_HOLD: begin
                    if (tmr_reg == 3'd0) begin
                        state_reg <= verify_reg ? S_VRD : S_NEXT;
                    end else begin
                        tmr_reg <= tmr_reg - 3'd1;
                    end
                end

                S_VRD: begin
                    // Address has been stable since SETUP; the registered read
                    // data for it is presented during VCMP.
                    state_reg <= S_VCMP;
                end

                S_VCMP: begin
                    if (dram_rdata != dram_wdata) begin
                        if (!err_h) begin
                            err_addr <= dram_addr;
                        end
                        err_h <= 1'b1;
                    end
                    state_reg <= S_NEXT;
                end

                S_NEXT: begin
                    dram_addr     <= dram_addr + 1'b1;
                    remaining_reg <= remaining_reg - 10'd1;
                    if (remaining_reg == 10'd1 || abort_any) begin
                        done_h    <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        wd_ready_h <= 1'b1;
                        state_reg  <= S_WAIT_DATA;
                    end
                end

                S_DONE: begin
                    busy_h    <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg  <= S_IDLE;
                    busy_h     <= 1'b0;
                    wd_ready_h <= 1'b0;
                    dram_we_l  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_load_seq.sv
module tb_dram_load_seq;

    logic        clk_h = 1'b0;
    logic        reset_l = 1'b0;
    logic        start_h = 1'b0;
    logic [8:0]  start_addr = '0;
    logic [9:0]  count = '0;
    logic        verify_h = 1'b0;
    logic        abort_h = 1'b0;
    logic        wd_valid_h = 1'b0;
    logic        wd_ready_h;
    logic [15:0] wd_data = '0;
    logic        con_load_dram_l = 1'b1;
    logic [8:0]  dram_addr;
    logic [16:0] dram_wdata;
    logic        dram_we_l;
    logic [16:0] dram_rdata = '0;
    logic        busy_h;
    logic        done_h;
    logic        err_h;
    logic [8:0]  err_addr;

    dram_load_seq #(.ADDR_W(9), .STROBE_CYC(2), .HOLD_CYC(1)) dut (
        .clk_h(clk_h), .reset_l(reset_l), .start_h(start_h), .start_addr(start_addr),
        .count(count), .verify_h(verify_h), .abort_h(abort_h), .wd_valid_h(wd_valid_h),
        .wd_ready_h(wd_ready_h), .wd_data(wd_data), .con_load_dram_l(con_load_dram_l),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we_l(dram_we_l),
        .dram_rdata(dram_rdata), .busy_h(busy_h), .done_h(done_h), .err_h(err_h),
        .err_addr(err_addr)
    );

    always #5 clk_h = ~clk_h;

    // DRAM model with registered read; can flip bit 3 on reads of one address.
    logic [16:0] mem [512];
    logic        corrupt_en = 1'b0;
    logic [8:0]  corrupt_addr = '0;
    always @(posedge clk_h) begin
        if (!dram_we_l) mem[dram_addr] <= dram_wdata;
        dram_rdata <= mem[dram_addr] ^ ((corrupt_en && dram_addr == corrupt_addr) ? 17'h00008 : 17'h00000);
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { logic [8:0] a; logic [16:0] d; } wr_t;
    typedef struct { logic e; logic [8:0] a; } dn_t;
    wr_t wr_q[$];
    dn_t done_q[$];

    // Monitor: one record per completed strobe and per done pulse.
    bit          mon_en = 1'b1;
    bit          busy_seen = 1'b0;
    int          done_cnt = 0;
    bit          in_strobe = 1'b0;
    bit          unstable = 1'b0;
    int          s_len = 0;
    logic [8:0]  s_addr;
    logic [16:0] s_data;

    always @(negedge clk_h) begin
        if (!mon_en) begin
            in_strobe = 1'b0;
        end else begin
            if (!dram_we_l) begin
                if (!in_strobe) begin
                    in_strobe = 1'b1;
                    s_addr = dram_addr;
                    s_data = dram_wdata;
                    s_len = 1;
                    unstable = 1'b0;
                end else begin
                    s_len++;
                    if (dram_addr != s_addr || dram_wdata != s_data) unstable = 1'b1;
                end
            end else if (in_strobe) begin
                in_strobe = 1'b0;
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: write addr=0x%0h data=0x%0h with none expected", s_addr, s_data);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(s_addr), 32'(e.a));
                    check("wr_data", 32'(s_data), 32'(e.d));
                    check("wr_strobe_len", 32'(s_len), 32'd2);
                    check("wr_stable", 32'(unstable), 32'd0);
                    $display("write addr=0x%03h data=0x%05h strobe=%0d", s_addr, s_data, s_len);
                end
            end
            if (done_h) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: done pulse with none expected");
                end else begin
                    dn_t d;
                    d = done_q.pop_front();
                    check("done_err", 32'(err_h), 32'(d.e));
                    check("done_err_addr", 32'(err_addr), 32'(d.a));
                    $display("done err=%0d err_addr=0x%03h", err_h, err_addr);
                end
            end
            if (busy_h) busy_seen = 1'b1;
        end
    end

    task automatic exp_wr(input logic [8:0] a, input logic [16:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wr_q.push_back(e);
    endtask

    task automatic exp_done(input logic e, input logic [8:0] a);
        dn_t d;
        d.e = e;
        d.a = a;
        done_q.push_back(d);
    endtask

    task automatic start_blk(input logic [8:0] a, input logic [9:0] c, input logic v);
        @(posedge clk_h);
        #1;
        start_h = 1'b1;
        start_addr = a;
        count = c;
        verify_h = v;
        @(posedge clk_h);
        #1;
        start_h = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk_h);
        #1;
        wd_valid_h = 1'b1;
        wd_data = d;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk_h);
            if (wd_ready_h) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        wd_valid_h = 1'b0;
        check("feed_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        int base;
        base = done_cnt;
        for (int n = 0; n < 300 && done_cnt == base; n++) @(posedge clk_h);
        repeat (4) @(posedge clk_h);
        check("done_pulses", 32'(done_cnt - base), 32'd1);
        check("wr_left", 32'(wr_q.size()), 32'd0);
        check("done_left", 32'(done_q.size()), 32'd0);
        check("busy_after", 32'(busy_h), 32'd0);
    endtask

    initial begin
        bit hit;

        // Reset state
        repeat (3) @(posedge clk_h);
        #1;
        reset_l = 1'b1;
        @(negedge clk_h);
        check("rst_wd_ready", 32'(wd_ready_h), 32'd0);
        check("rst_we_l", 32'(dram_we_l), 32'd1);
        check("rst_busy", 32'(busy_h), 32'd0);
        check("rst_done", 32'(done_h), 32'd0);
        check("rst_err", 32'(err_h), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        check("rst_dram_addr", 32'(dram_addr), 32'd0);
        check("rst_dram_wdata", 32'(dram_wdata), 32'd0);

        // Plain write. 0x1234 has five ones, so its odd-parity bit is 0.
        exp_wr(9'h1F0, 17'h10000);
        exp_wr(9'h1F1, 17'h1FFFF);
        exp_wr(9'h1F2, 17'h01234);
        exp_done(1'b0, 9'h000);
        start_blk(9'h1F0, 10'd3, 1'b0);
        feed(16'h0000);
        feed(16'hFFFF);
        feed(16'h1234);
        wait_done();

        // Address wrap 0x1FF -> 0x000
        exp_wr(9'h1FF, 17'h1A5A5);
        exp_wr(9'h000, 17'h00001);
        exp_done(1'b0, 9'h000);
        start_blk(9'h1FF, 10'd2, 1'b0);
        feed(16'hA5A5);
        feed(16'h0001);
        wait_done();

        // Verify with corrupted read-back of the second entry
        corrupt_en = 1'b1;
        corrupt_addr = 9'h051;
        exp_wr(9'h050, 17'h100FF);
        exp_wr(9'h051, 17'h07000);
        exp_done(1'b1, 9'h051);
        start_blk(9'h050, 10'd2, 1'b1);
        feed(16'h00FF);
        feed(16'h7000);
        wait_done();
        corrupt_en = 1'b0;

        // count = 0: done only, error from previous block cleared
        exp_done(1'b0, 9'h000);
        start_blk(9'h010, 10'd0, 1'b0);
        wait_done();

        // count = 600: error, no writes, never busy
        busy_seen = 1'b0;
        exp_done(1'b1, 9'h123);
        start_blk(9'h123, 10'd600, 1'b0);
        wait_done();
        check("oversize_busy_seen", 32'(busy_seen), 32'd0);

        // Start while CON dispatch read in progress
        @(posedge clk_h);
        #1;
        start_h = 1'b1;
        start_addr = 9'h0A0;
        count = 10'd1;
        verify_h = 1'b0;
        con_load_dram_l = 1'b0;
        exp_wr(9'h0A0, 17'h10003);
        exp_done(1'b0, 9'h000);
        @(posedge clk_h);
        #1;
        start_h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_h);
            check("con_hold_busy", 32'(busy_h), 32'd0);
            if (i < 3) @(posedge clk_h);
        end
        con_load_dram_l = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 6 && !hit; n++) begin
            @(negedge clk_h);
            if (busy_h) hit = 1'b1;
        end
        check("con_release_busy", 32'(hit), 32'd1);
        feed(16'h0003);
        wait_done();

        // Abort during the first strobe of a 5-word block
        exp_wr(9'h100, 17'h10F0F);
        exp_done(1'b0, 9'h000);
        start_blk(9'h100, 10'd5, 1'b0);
        feed(16'h0F0F);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk_h);
            if (!dram_we_l) hit = 1'b1;
        end
        check("abort_strobe_seen", 32'(hit), 32'd1);
        abort_h = 1'b1;
        @(posedge clk_h);
        #1;
        abort_h = 1'b0;
        wait_done();

        // Reset during a strobe: strobe released and busy dropped at next edge
        mon_en = 1'b0;
        start_blk(9'h020, 10'd2, 1'b0);
        feed(16'h0000);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk_h);
            if (!dram_we_l) hit = 1'b1;
        end
        check("rst_strobe_seen", 32'(hit), 32'd1);
        reset_l = 1'b0;
        @(negedge clk_h);
        check("rst_mid_we_l", 32'(dram_we_l), 32'd1);
        check("rst_mid_busy", 32'(busy_h), 32'd0);
        check("rst_mid_ready", 32'(wd_ready_h), 32'd0);
        @(posedge clk_h);
        #1;
        reset_l = 1'b1;
        busy_seen = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(posedge clk_h);
        check("rst_no_resume", 32'(busy_seen), 32'd0);
        check("rst_no_writes", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
